// File: rtl/mc_control.sv
// Multicycle control FSM for the RV32I-subset core: sequences fetch/decode/exec/mem/wb
// over the shared datapath, owns the memory handshake and traps on illegal opcodes or hung memory.
//
// state  | meaning
// FETCH  | request instruction word, load IR on mem_ready
// DECODE | classify opcode, latch class and imm_sel
// EXEC   | ALU operation; branches and jumps finish here
// MEM    | load/store access, waits on mem_ready
// WB     | register writeback and PC advance
// TRAP   | fault parked, only reset leaves
module mc_control #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [2:0]  imm_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } cls_t;

  // Wait timer runs down from TIMEOUT; terminal count at zero equals TIMEOUT elapsed cycles.
  localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT);

  state_t        state, state_nxt;
  cls_t          cls, cls_dec;
  logic [2:0]    imm_q, imm_dec;
  logic          legal;
  logic [CW-1:0] wait_left;
  logic          waiting, wait_tc;
  logic          trap_q, trap_set;
  logic [1:0]    cause_q, cause_nxt;
  logic          unused_inst;

  assign unused_inst = ^inst[31:7];

  always_comb begin
    cls_dec = C_OP;
    imm_dec = 3'b000;
    legal   = 1'b1;
    case (inst[6:0])
      7'b0010011: begin cls_dec = C_OPIMM;  imm_dec = 3'b000; end
      7'b0000011: begin cls_dec = C_LOAD;   imm_dec = 3'b001; end
      7'b0100011: begin cls_dec = C_STORE;  imm_dec = 3'b010; end
      7'b1100111: begin cls_dec = C_JALR;   imm_dec = 3'b011; end
      7'b1101111: begin cls_dec = C_JAL;    imm_dec = 3'b100; end
      7'b1100011: begin cls_dec = C_BRANCH; imm_dec = 3'b110; end
      7'b0110011: begin cls_dec = C_OP;     imm_dec = 3'b000; end
      default:    legal = 1'b0;
    endcase
  end

  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  assign wait_tc = (wait_left == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_left <= WAIT_LOAD;
      cls       <= C_OP;
      imm_q     <= 3'b000;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_left <= WAIT_LOAD;
      else if (waiting && !wait_tc)
        wait_left <= wait_left - CW'(1);
      if ((state == S_DECODE) && legal) begin
        cls   <= cls_dec;
        imm_q <= imm_dec;
      end
      if (trap_set) begin
        trap_q  <= 1'b1;
        cause_q <= cause_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    trap_set  = 1'b0;
    cause_nxt = cause_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 2'b00;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    alu_src_b = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_tc) begin
          state_nxt = S_TRAP;
          trap_set  = 1'b1;
          cause_nxt = 2'b10;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          trap_set  = 1'b1;
          cause_nxt = 2'b01;
        end
      end
      S_EXEC: begin
        case (cls)
          C_OP:    state_nxt = S_WB;
          C_OPIMM: begin alu_src_b = 1'b1; state_nxt = S_WB; end
          C_LOAD,
          C_STORE: begin alu_src_b = 1'b1; state_nxt = S_MEM; end
          C_BRANCH: begin
            pc_write  = 1'b1;
            pc_sel    = br_taken ? 2'b01 : 2'b00;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          C_JAL, C_JALR: begin
            alu_src_b = (cls == C_JALR);
            reg_we    = 1'b1;
            wb_sel    = 2'b10;
            pc_write  = 1'b1;
            pc_sel    = (cls == C_JALR) ? 2'b10 : 2'b01;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (cls == C_STORE);
        alu_src_b = 1'b1;
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_write  = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_tc) begin
          state_nxt = S_TRAP;
          trap_set  = 1'b1;
          cause_nxt = 2'b10;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        wb_sel    = (cls == C_LOAD) ? 2'b01 : 2'b00;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
    // The reset cycle shows a quiet datapath whatever state is being abandoned.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = 2'b00;
      reg_we    = 1'b0;
      wb_sel    = 2'b00;
      alu_src_b = 1'b0;
      retire    = 1'b0;
    end
  end

  assign imm_sel    = rst ? 3'b000 : imm_q;
  assign trap       = trap_q & ~rst;
  assign trap_cause = rst ? 2'b00 : cause_q;
  assign state_o    = state;

endmodule
